branch_target_buffer: RTL and testbench

//  IF-stage branch predictor: direct-mapped BTB with 2-bit saturating counters. Predicts taken/target
//  for PCF each cycle and is trained in EX by the resolved BranchE/BranchTypeE. It also reports

---
 rtl/branch_target_buffer_pkg.sv | 29 ++
 rtl/branch_target_buffer_if.sv | 41 ++++
 rtl/branch_target_buffer_sat_counter2.sv | 30 +++
 rtl/branch_target_buffer.sv | 126 ++++++++++++
 tb/tb_branch_target_buffer.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared types for the branch target buffer: branch-type encodings,
// 2-bit counter states and a saturating perf-counter helper.
package branch_target_buffer_pkg;

    // Branch types decoded in ID and carried to EX with the instruction.
    typedef enum logic [2:0] {
        NOBRANCH = 3'd0,
        BEQ      = 3'd1,
        BNE      = 3'd2,
        BLT      = 3'd3,
        BLTU     = 3'd4,
        BGE      = 3'd5,
        BGEU     = 3'd6
    } branch_type_e;

    // 2-bit direction predictor states; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
        return (en && (value != '1)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup, EX-side training/resolve and perf-counter signals
// of the branch target buffer, grouped as one bundle.
interface branch_target_buffer_if;

    // IF-stage lookup
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;

    // EX-stage resolve / training
    logic        UpdateEnE;
    logic [2:0]  BranchTypeE;
    logic        BranchE;
    logic [31:0] PCE;
    logic [31:0] BranchTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredictE;
    logic [31:0] CorrectPCE;

    // Perf counters
    logic [31:0] BranchCnt;
    logic [31:0] MissCnt;

    // Pipeline side
    modport master (
        output PCF, UpdateEnE, BranchTypeE, BranchE, PCE, BranchTargetE,
               PredTakenE, PredTargetE,
        input  PredTakenF, PredTargetF, MispredictE, CorrectPCE,
               BranchCnt, MissCnt
    );

    // Predictor side
    modport slave (
        input  PCF, UpdateEnE, BranchTypeE, BranchE, PCE, BranchTargetE,
               PredTakenE, PredTargetE,
        output PredTakenF, PredTargetF, MispredictE, CorrectPCE,
               BranchCnt, MissCnt
    );

endinterface

// File: rtl/branch_target_buffer_sat_counter2.sv
// 2-bit saturating counter next-state function (SNT<->WNT<->WT<->ST).
// Pure combinational so any predictor table can wrap its own storage around it.
module sat_counter2
    import branch_target_buffer_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    cnt_state_e state;
    cnt_state_e state_next;

    assign state = cnt_state_e'(cnt);

    // Step towards taken or not-taken, holding at either end.
    always_comb begin
        state_next = state;
        case (state)
            SNT:     state_next = taken ? WNT : SNT;
            WNT:     state_next = taken ? WT  : SNT;
            WT:      state_next = taken ? ST  : WNT;
            ST:      state_next = taken ? ST  : WT;
            default: state_next = state;
        endcase
    end

    assign cnt_next = state_next;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Combinational lookup for the fetch PC, training from the resolved EX
// branch, mispredict/redirect generation and saturating perf counters.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned TAG_BITS = 8,
    parameter logic [1:0]  CNT_INIT = 2'b10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_target_buffer_if.slave bus
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int unsigned IDX_MSB = IDX_BITS + 1;
    localparam int unsigned TAG_LSB = IDX_BITS + 2;
    localparam int unsigned TAG_MSB = IDX_BITS + TAG_BITS + 1;

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [31:0]         target_d [ENTRIES];
    logic [1:0]          cnt_q    [ENTRIES];
    logic [1:0]          cnt_d    [ENTRIES];
    logic [31:0]         branch_cnt_q, branch_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;

    logic [IDX_BITS-1:0] idx_f, idx_e;
    logic [TAG_BITS-1:0] tag_f, tag_e;
    logic                hit_f, hit_e;
    logic                resolve;
    logic                mispredict;
    logic [1:0]          cnt_trained;

    // PC bits outside index/tag take no part in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.PCF[1:0], bus.PCF[31:TAG_MSB+1],
                              bus.PCE[1:0], bus.PCE[31:TAG_MSB+1]};

    assign idx_f = bus.PCF[IDX_MSB:2];
    assign tag_f = bus.PCF[TAG_MSB:TAG_LSB];
    assign idx_e = bus.PCE[IDX_MSB:2];
    assign tag_e = bus.PCE[TAG_MSB:TAG_LSB];

    // Fetch lookup from the registered arrays; forced to miss while in reset.
    always_comb begin
        hit_f           = rst_n && valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        bus.PredTakenF  = hit_f && cnt_q[idx_f][1];
        bus.PredTargetF = hit_f ? target_q[idx_f] : bus.PCF + 32'd4;
    end

    // Resolve the EX branch against the prediction it carried down the pipe.
    always_comb begin
        resolve    = bus.UpdateEnE && (bus.BranchTypeE != NOBRANCH);
        mispredict = resolve && ((bus.BranchE != bus.PredTakenE) ||
                                 (bus.BranchE && (bus.PredTargetE != bus.BranchTargetE)));
        bus.MispredictE = mispredict;
        bus.CorrectPCE  = '0;
        if (resolve) begin
            bus.CorrectPCE = bus.BranchE ? bus.BranchTargetE : bus.PCE + 32'd4;
        end
    end

    sat_counter2 u_sat_counter2 (
        .cnt      (cnt_q[idx_e]),
        .taken    (bus.BranchE),
        .cnt_next (cnt_trained)
    );

    // Train the entry at the EX index: update on hit, allocate on taken miss.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
        if (resolve) begin
            if (hit_e) begin
                cnt_d[idx_e] = cnt_trained;
                if (bus.BranchE) begin
                    target_d[idx_e] = bus.BranchTargetE;
                end
            end else if (bus.BranchE) begin
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = tag_e;
                target_d[idx_e] = bus.BranchTargetE;
                cnt_d[idx_e]    = CNT_INIT;
            end
        end
    end

    // Perf counters, both sticking at all-ones.
    always_comb begin
        branch_cnt_d = sat_inc32(branch_cnt_q, resolve);
        miss_cnt_d   = sat_inc32(miss_cnt_q, mispredict);
    end

    // Valid bits and perf counters are the only reset state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= '0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Payload arrays are not reset; writes are held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.BranchCnt = branch_cnt_q;
    assign bus.MissCnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed, table-driven bench for branch_target_buffer: one record per
// clock cycle with inputs and the hand-computed outputs for that cycle.
module tb_branch_target_buffer;
    import branch_target_buffer_pkg::*;

    logic clk;
    logic rst_n;

    branch_target_buffer_if bif ();

    branch_target_buffer #(
        .IDX_BITS (6),
        .TAG_BITS (8),
        .CNT_INIT (2'b10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [31:0] pcf;
        logic        upd;
        logic [2:0]  bt;
        logic        br;
        logic [31:0] pce;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptg;
        logic        e_ptk;
        logic [31:0] e_ptg;
        logic        e_mis;
        logic [31:0] e_cpc;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input logic r, input logic [31:0] pcf, input logic upd,
                                input logic [2:0] bt, input logic br, input logic [31:0] pce,
                                input logic [31:0] tgt, input logic ptk, input logic [31:0] ptg,
                                input logic e_ptk, input logic [31:0] e_ptg, input logic e_mis,
                                input logic [31:0] e_cpc, input logic [31:0] e_bc,
                                input logic [31:0] e_mc);
        vec_t v;
        v.rst_n = r;   v.pcf = pcf;     v.upd = upd;     v.bt = bt;       v.br = br;
        v.pce = pce;   v.tgt = tgt;     v.ptk = ptk;     v.ptg = ptg;
        v.e_ptk = e_ptk; v.e_ptg = e_ptg; v.e_mis = e_mis; v.e_cpc = e_cpc;
        v.e_bc = e_bc; v.e_mc = e_mc;
        vecs.push_back(v);
    endfunction

    function automatic void idle(input logic [31:0] pcf, input logic e_ptk,
                                 input logic [31:0] e_ptg, input logic [31:0] e_bc,
                                 input logic [31:0] e_mc);
        add(1'b1, pcf, 1'b0, NOBRANCH, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
            e_ptk, e_ptg, 1'b0, 32'h0, e_bc, e_mc);
    endfunction

    task automatic apply(input vec_t v);
        rst_n             = v.rst_n;
        bif.PCF           = v.pcf;
        bif.UpdateEnE     = v.upd;
        bif.BranchTypeE   = v.bt;
        bif.BranchE       = v.br;
        bif.PCE           = v.pce;
        bif.BranchTargetE = v.tgt;
        bif.PredTakenE    = v.ptk;
        bif.PredTargetE   = v.ptg;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, " PredTakenF"},  {31'd0, bif.PredTakenF},  {31'd0, v.e_ptk});
        check({tag, " PredTargetF"}, bif.PredTargetF,          v.e_ptg);
        check({tag, " MispredictE"}, {31'd0, bif.MispredictE}, {31'd0, v.e_mis});
        check({tag, " CorrectPCE"},  bif.CorrectPCE,           v.e_cpc);
        check({tag, " BranchCnt"},   bif.BranchCnt,            v.e_bc);
        check({tag, " MissCnt"},     bif.MissCnt,              v.e_mc);
    endtask

    initial begin
        vec_t v;

        //   rst pcf           upd bt        br pce           tgt       ptk ptg          | e_ptk e_ptg     mis cpc       bc  mc
        idle(32'h100, 1'b0, 32'h104, 0, 0);
        add(1, 32'h100,       1, BEQ,      1, 32'h100,      32'h80,  0, 32'h104,      0, 32'h104, 1, 32'h80,  0, 0);
        idle(32'h100, 1'b1, 32'h80, 1, 1);
        add(1, 32'h100,       1, BEQ,      0, 32'h100,      32'h80,  1, 32'h80,       1, 32'h80,  1, 32'h104, 1, 1);
        add(1, 32'h100,       1, BEQ,      0, 32'h100,      32'h80,  0, 32'h80,       0, 32'h80,  0, 32'h104, 2, 2);
        idle(32'h100, 1'b0, 32'h80, 3, 2);
        add(1, 32'h100,       1, BEQ,      0, 32'h100,      32'h80,  0, 32'h80,       0, 32'h80,  0, 32'h104, 3, 2);
        add(1, 32'h100,       1, BEQ,      1, 32'h100,      32'h80,  0, 32'h80,       0, 32'h80,  1, 32'h80,  4, 2);
        add(1, 32'h100,       1, BEQ,      1, 32'h100,      32'h80,  0, 32'h80,       0, 32'h80,  1, 32'h80,  5, 3);
        add(1, 32'h100,       1, BEQ,      1, 32'h100,      32'h80,  1, 32'h80,       1, 32'h80,  0, 32'h80,  6, 4);
        add(1, 32'h100,       1, BEQ,      1, 32'h100,      32'h80,  1, 32'h80,       1, 32'h80,  0, 32'h80,  7, 4);
        add(1, 32'h100,       1, BEQ,      0, 32'h100,      32'h80,  1, 32'h80,       1, 32'h80,  1, 32'h104, 8, 4);
        idle(32'h100, 1'b1, 32'h80, 9, 5);
        add(1, 32'h100,       1, BEQ,      1, 32'h100,      32'h90,  1, 32'h80,       1, 32'h80,  1, 32'h90,  9, 5);
        idle(32'h100, 1'b1, 32'h90, 10, 6);
        add(1, 32'h100,       0, BNE,      1, 32'h100,      32'h200, 0, 32'h104,      1, 32'h90,  0, 32'h0,   10, 6);
        idle(32'h100, 1'b1, 32'h90, 10, 6);
        add(1, 32'h100,       1, NOBRANCH, 1, 32'h100,      32'h200, 0, 32'h104,      1, 32'h90,  0, 32'h0,   10, 6);
        idle(32'h100, 1'b1, 32'h90, 10, 6);
        add(1, 32'h100,       1, BEQ,      0, 32'hFFFFFFFC, 32'h0,   1, 32'h0,        1, 32'h90,  1, 32'h0,   10, 6);
        idle(32'hFFFFFFFC, 1'b0, 32'h0, 11, 7);
        idle(32'h200, 1'b0, 32'h204, 11, 7);
        add(1, 32'h100,       1, BEQ,      1, 32'h200,      32'h300, 0, 32'h204,      1, 32'h90,  1, 32'h300, 11, 7);
        idle(32'h100, 1'b0, 32'h104, 12, 8);
        idle(32'h200, 1'b1, 32'h300, 12, 8);
        add(0, 32'h200,       1, BEQ,      1, 32'h200,      32'h400, 1, 32'h300,      0, 32'h204, 1, 32'h400, 12, 8);
        idle(32'h200, 1'b0, 32'h204, 0, 0);
        add(1, 32'h200,       1, BEQ,      1, 32'h200,      32'h500, 0, 32'h204,      0, 32'h204, 1, 32'h500, 0, 0);
        idle(32'h200, 1'b1, 32'h500, 1, 1);

        // Reset with the EX slot idle.
        v = vecs[0];
        v.rst_n = 1'b0;
        apply(v);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            #1;
            apply(vecs[i]);
            @(negedge clk);
            check_vec($sformatf("row%0d", i), vecs[i]);
            @(posedge clk);
        end

        // Neighbouring index allocates independently of the entry at index 0.
        #1;
        add(1, 32'h104, 1, BNE, 1, 32'h104, 32'h40, 0, 32'h108, 0, 32'h108, 1, 32'h40, 1, 1);
        v = vecs[vecs.size()-1];
        apply(v);
        @(negedge clk);
        check_vec("alloc_idx1", v);
        @(posedge clk);
        #1;
        idle(32'h104, 1'b1, 32'h40, 2, 2);
        v = vecs[vecs.size()-1];
        apply(v);
        #2;
        check_vec("hit_idx1", v);
        v.pcf   = 32'h200;
        v.e_ptg = 32'h500;
        apply(v);
        #2;
        check_vec("hit_idx0_kept", v);
        @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
